vlc_stream_serializer: RTL and testbench

//  Buffers variable-length codewords {len, code} in a parametrised FIFO and emits each as a bit stream.

---
 rtl/vlc_stream_serializer_pkg.sv | 13 +
 rtl/vlc_sync_fifo.sv | 43 ++++
 rtl/vlc_stream_serializer.sv | 113 +++++++++++
 tb/tb_vlc_stream_serializer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vlc_stream_serializer_pkg.sv
// Shared defaults and FSM state encoding for the VLC bit-stream serializer.
package vlc_stream_serializer_pkg;

  localparam int VLC_CODE_W     = 16;
  localparam int VLC_LEN_W      = 5;
  localparam int VLC_FIFO_DEPTH = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } vlc_state_e;

endpackage

// File: rtl/vlc_sync_fifo.sv
// Synchronous FIFO with registered write and combinational read data.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module vlc_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 21,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] wptr, rptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + CNT_W'(1);
      if (pop)  rptr <= rptr + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rptr[AW-1:0]];
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;

endmodule

// File: rtl/vlc_stream_serializer.sv
// Buffers {len, code} codewords and emits them as a valid/ready bit stream,
// MSB-first or LSB-first per word, with gapless word-to-word hand-off.
module vlc_stream_serializer
  import vlc_stream_serializer_pkg::*;
#(
  parameter int CODE_W = VLC_CODE_W,
  parameter int LEN_W  = VLC_LEN_W,
  parameter int DEPTH  = VLC_FIFO_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LEN_W+CODE_W-1:0] d_in,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic                    lsb_first,
  output logic                    d_out,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic [CNT_W-1:0]        fifo_count,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    len_err
);

  localparam int WORD_W = LEN_W + CODE_W;

  vlc_state_e        state, state_nxt;
  logic [WORD_W-1:0] rd_word;
  logic [LEN_W-1:0]  rd_len, rd_len_eff, remaining;
  logic [CODE_W-1:0] rd_code, shreg;
  logic              order_lsb, push, pop, load, take, last_take;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (int'(l) > CODE_W) return LEN_W'(CODE_W);
    return l;
  endfunction

  // Left-justify the active bits so MSB-first always shifts out of the top bit.
  function automatic logic [CODE_W-1:0] align_msb(input logic [CODE_W-1:0] c,
                                                  input logic [LEN_W-1:0]  l);
    int sh;
    sh = CODE_W - int'(l);
    return c << sh;
  endfunction

  vlc_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (d_in),
    .pop     (pop),
    .rd_data (rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign din_ready              = !fifo_full;
  assign push                   = din_valid && din_ready;
  assign {rd_len, rd_code}      = rd_word;
  assign rd_len_eff             = clamp_len(rd_len);
  assign take                   = (state == ST_SHIFT) && dout_ready;
  assign last_take              = take && (remaining == LEN_W'(1));
  assign pop                    = !fifo_empty && ((state == ST_IDLE) || last_take);
  assign load                   = pop && (rd_len != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (load) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_take) state_nxt = load ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining <= '0;
      order_lsb <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      len_err <= pop && (int'(rd_len) > CODE_W);
      if (load) begin
        remaining <= rd_len_eff;
        order_lsb <= lsb_first;
      end else if (take) begin
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load)      shreg <= lsb_first ? rd_code : align_msb(rd_code, rd_len_eff);
    else if (take) shreg <= order_lsb ? (shreg >> 1) : (shreg << 1);
  end

  // Outputs are gated by the registered state so they read 0 whenever idle.
  assign dout_valid = (state == ST_SHIFT);
  assign d_out      = dout_valid && (order_lsb ? shreg[0] : shreg[CODE_W-1]);
  assign dout_last  = dout_valid && (remaining == LEN_W'(1));

endmodule

// File: tb/tb_vlc_stream_serializer.sv
// Self-checking bench for vlc_stream_serializer: directed vector table,
// hand-written corner sequences and randomized traffic against a bit-queue model.
`timescale 1ns/1ps
module tb_vlc_stream_serializer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [20:0] d_in = '0;
  logic        din_valid = 1'b0, din_ready, lsb_first = 1'b0;
  logic        d_out, dout_valid, dout_ready = 1'b0, dout_last;
  logic [4:0]  fifo_count;
  logic        fifo_full, fifo_empty, len_err;

  vlc_stream_serializer dut (
    .clk(clk), .rst(rst), .d_in(d_in), .din_valid(din_valid), .din_ready(din_ready),
    .lsb_first(lsb_first), .d_out(d_out), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .fifo_count(fifo_count), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic b; logic last; } bit_t;
  typedef struct {
    logic [4:0]  len;
    logic [15:0] code;
    logic        lsb;
    int          n;
    logic [15:0] bits;   // bit i = i-th emitted bit
    int          err;
  } vec_t;

  int   errors = 0, checks = 0;
  int   seen_err = 0, exp_err = 0;
  bit_t exp_q[$];
  logic prev_stall = 1'b0;
  logic [1:0] prev_bits = '0;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a codeword becomes min(len,16) bits in the chosen order.
  task automatic model_push(input logic [20:0] w, input logic lsb);
    int l, eff;
    bit_t e;
    l = int'(w[20:16]);
    if (l == 0) return;
    if (l > 16) begin eff = 16; exp_err++; end
    else eff = l;
    for (int k = 0; k < eff; k++) begin
      e.b    = lsb ? w[k] : w[eff-1-k];
      e.last = (k == eff - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic cycle(input logic v, input logic [20:0] w, input logic r, output logic acc);
    bit_t e;
    @(negedge clk);
    din_valid = v; d_in = w; dout_ready = r;
    #1;
    if (len_err) seen_err++;
    if (prev_stall) begin
      chk("hold_valid", 32'(dout_valid), 32'd1);
      chk("hold_bits", 32'({d_out, dout_last}), 32'(prev_bits));
    end
    prev_stall = dout_valid && !dout_ready;
    prev_bits  = {d_out, dout_last};
    if (dout_valid && dout_ready) begin
      if (exp_q.size() == 0) chk("extra_bit", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("stream_bit", 32'(d_out), 32'(e.b));
        chk("stream_last", 32'(dout_last), 32'(e.last));
      end
    end
    acc = din_valid && din_ready;
    if (acc) model_push(w, lsb_first);
  endtask

  task automatic drain(input logic rnd);
    int   k;
    logic acc;
    k = 0;
    while ((exp_q.size() != 0 || dout_valid || !fifo_empty) && k < 3000) begin
      cycle(1'b0, '0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc);
      k++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", 32'(dout_valid), 32'd0);
    chk("len_err_count", 32'(seen_err), 32'(exp_err));
  endtask

  function automatic logic [20:0] rnd_word();
    logic [4:0]  l;
    logic [15:0] c;
    l = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
    c = 16'($urandom);
    return {l, c};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc, done;
    logic [15:0] got;
    int          n, errs, first, vcnt, accepted, e0;

    tbl[0] = '{5'd3,  16'h0005, 1'b0, 3,  16'h0005, 0};
    tbl[1] = '{5'd3,  16'h0005, 1'b1, 3,  16'h0005, 0};
    tbl[2] = '{5'd4,  16'h0003, 1'b1, 4,  16'h0003, 0};
    tbl[3] = '{5'd4,  16'h0003, 1'b0, 4,  16'h000C, 0};
    tbl[4] = '{5'd5,  16'hFFE6, 1'b0, 5,  16'h000C, 0};
    tbl[5] = '{5'd20, 16'h8001, 1'b0, 16, 16'h8001, 1};
    tbl[6] = '{5'd16, 16'h1234, 1'b1, 16, 16'h1234, 0};
    tbl[7] = '{5'd1,  16'h0000, 1'b0, 1,  16'h0000, 0};
    tbl[8] = '{5'd31, 16'hA5A5, 1'b1, 16, 16'hA5A5, 1};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_din_ready", 32'(din_ready), 32'd1);
    chk("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    chk("rst_outputs", 32'({d_out, dout_valid, dout_last, fifo_full, len_err}), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      d_in = {tbl[i].len, tbl[i].code}; lsb_first = tbl[i].lsb; dout_ready = 1'b1; din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      #1 chk("tbl_not_early", 32'(dout_valid), 32'd0);
      n = 0; got = '0; errs = 0; first = -1; done = 1'b0;
      for (int c = 0; c < 24 && !done; c++) begin
        @(negedge clk);
        #1;
        if (len_err) errs++;
        if (dout_valid) begin
          if (first < 0) first = c;
          if (n < 16) got[n] = d_out;
          n++;
          done = dout_last;
        end
      end
      chk($sformatf("tbl%0d_latency", i), 32'(first), 32'd0);
      chk($sformatf("tbl%0d_nbits", i), 32'(n), 32'(tbl[i].n));
      chk($sformatf("tbl%0d_bits", i), 32'(got), 32'(tbl[i].bits));
      chk($sformatf("tbl%0d_len_err", i), 32'(errs), 32'(tbl[i].err));
      @(negedge clk);
      #1 chk($sformatf("tbl%0d_idle", i), 32'(dout_valid), 32'd0);
    end

    // Fill the FIFO behind a stalled shifter
    lsb_first = 1'b0;
    accepted = 0;
    for (int c = 0; c < 60 && accepted < DEPTH + 1; c++) begin
      cycle(1'b1, {5'd4, 12'd0, 4'(accepted)}, 1'b0, acc);
      if (acc) accepted++;
    end
    chk("fill_accepted", 32'(accepted), 32'(DEPTH + 1));
    repeat (3) cycle(1'b1, {5'd4, 16'h000F}, 1'b0, acc);
    chk("fill_full", 32'(fifo_full), 32'd1);
    chk("fill_din_ready", 32'(din_ready), 32'd0);
    chk("fill_count", 32'(fifo_count), 32'(DEPTH));
    chk("fill_stalled_valid", 32'(dout_valid), 32'd1);
    drain(1'b0);

    // Back-to-back words, no bubble
    cycle(1'b1, {5'd2, 16'b10}, 1'b1, acc);
    cycle(1'b1, {5'd1, 16'b1}, 1'b1, acc);
    vcnt = 0;
    repeat (3) begin
      cycle(1'b0, '0, 1'b1, acc);
      vcnt += int'(dout_valid);
    end
    chk("b2b_contiguous", 32'(vcnt), 32'd3);
    cycle(1'b0, '0, 1'b1, acc);
    chk("b2b_done", 32'(dout_valid), 32'd0);
    drain(1'b0);

    // Zero-length drop, oversize clamp
    e0 = seen_err;
    cycle(1'b1, {5'd0, 16'hFFFF}, 1'b1, acc);
    cycle(1'b1, {5'd20, 16'hABCD}, 1'b1, acc);
    drain(1'b0);
    chk("clamp_len_err_once", 32'(seen_err - e0), 32'd1);

    // Randomized traffic in each bit order
    for (int ph = 0; ph < 2; ph++) begin
      lsb_first = 1'(ph);
      for (int c = 0; c < 300; c++)
        cycle(1'($urandom_range(0, 1)), rnd_word(), $urandom_range(0, 3) != 0, acc);
      drain(1'b1);
    end

    // Reset mid-word
    for (int c = 0; c < 8; c++)
      cycle(c < 4, {5'd16, 16'($urandom)}, 1'($urandom_range(0, 1)), acc);
    #2 rst = 1'b0;
    #1;
    chk("midrst_outputs", 32'({d_out, dout_valid, dout_last, fifo_full, len_err}), 32'd0);
    chk("midrst_empty", 32'(fifo_empty), 32'd1);
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_din_ready", 32'(din_ready), 32'd1);
    exp_q.delete();
    exp_err = 0; seen_err = 0; prev_stall = 1'b0;
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, {5'd3, 16'b101}, 1'b1, acc);
    chk("post_rst_accept", 32'(acc), 32'd1);
    drain(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
